// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
//   Sequential radix-2 Booth multiplier. It performs one Booth step per clock
//   and needs WIDTH+1 steps per product. Each operand is widened by one bit,
//   with sign extension or zero extension chosen by signed_mode. Because of
//   that extra bit, a single recoder gives exact results for both signed and
//   unsigned operands.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   multiplicand        : operand A, WIDTH bits
//   multiplier          : operand B, WIDTH bits
//   signed_mode         : 1 = two's complement operands, 0 = unsigned
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   product             : 2*WIDTH-bit result, updated only on entry to DONE
//   busy                : high while iterating (CALC)
module booth_multiplier_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+2)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int EW = WIDTH + 1;  // extended operand width
  localparam int AW = WIDTH + 2;  // accumulator: add/sub never overflows

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [EW-1:0]      mq_q, mq_d;       // multiplier, shifted right each step
  logic               qm1_q, qm1_d;     // Booth Q(-1)
  logic [EW-1:0]      mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [AW-1:0]      mcand_ext;
  logic [AW-1:0]      acc_sum;
  logic [AW-1:0]      step_acc;
  logic [EW-1:0]      step_q;
  logic               last_step;

  // One Booth step: recode (Q0,Q-1), add/sub into the accumulator, then
  // arithmetic right shift of {acc, Q, Q-1}.
  always_comb begin
    mcand_ext = {mcand_q[EW-1], mcand_q};
    case ({mq_q[0], qm1_q})
      2'b10:   acc_sum = acc_q - mcand_ext;
      2'b01:   acc_sum = acc_q + mcand_ext;
      default: acc_sum = acc_q;
    endcase
    step_acc  = {acc_sum[AW-1], acc_sum[AW-1:1]};
    step_q    = {acc_sum[0], mq_q[EW-1:1]};
    last_step = (cnt_q == CNT_W'(WIDTH));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = {signed_mode & multiplicand[WIDTH-1], multiplicand};
          mq_d    = {signed_mode & multiplier[WIDTH-1], multiplier};
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = step_acc;
        mq_d  = step_q;
        qm1_d = mq_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          // The low 2*WIDTH bits of the {acc, Q} result are the exact product.
          prod_d  = {step_acc[WIDTH-2:0], step_q};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        iv32, ir32, sm32, ov32, or32, bz32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  // 8-bit instance
  logic        iv8, ir8, sm8, ov8, or8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  booth_multiplier_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .multiplicand(a32), .multiplier(b32), .signed_mode(sm32),
    .out_valid(ov32), .out_ready(or32), .product(p32), .busy(bz32));

  booth_multiplier_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .multiplicand(a8), .multiplier(b8), .signed_mode(sm8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bz8));

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  // Full transaction on the 32-bit instance; junk in_valid traffic during
  // CALC/DONE must be ignored. stall = cycles of out_ready=0 in DONE.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input int stall);
    int w, lat;
    logic [63:0] prev, exp;
    w = 0;
    while (!ir32 && w < 50) begin tick(); w++; end
    chk("in_ready32", {63'b0, ir32}, 64'd1);
    prev = p32;
    iv32 = 1'b1; a32 = a; b32 = b; sm32 = s;
    sb32.push_back(ref32(a, b, s));
    tick();
    chk("busy32", {63'b0, bz32}, 64'd1);
    chk("hold_calc32", p32, prev);
    a32 = $urandom; b32 = $urandom; sm32 = ~s;
    lat = 0;
    while (!ov32 && lat < 100) begin tick(); lat++; end
    chk("latency32", 64'(lat), 64'd33);
    exp = sb32.pop_front();
    chk("product32", p32, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("bp_valid32", {63'b0, ov32}, 64'd1);
      chk("bp_prod32", p32, exp);
      chk("bp_ready32", {63'b0, ir32}, 64'd0);
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    tick();
    or32 = 1'b0;
    chk("post_hs_valid32", {63'b0, ov32}, 64'd0);
    chk("post_hs_ready32", {63'b0, ir32}, 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int w, lat;
    w = 0;
    while (!ir8 && w < 50) begin tick(); w++; end
    chk("in_ready8", {63'b0, ir8}, 64'd1);
    iv8 = 1'b1; a8 = a; b8 = b; sm8 = s;
    sb8.push_back(ref8(a, b, s));
    tick();
    iv8 = 1'b0; a8 = $urandom; b8 = $urandom;
    lat = 0;
    while (!ov8 && lat < 50) begin tick(); lat++; end
    chk("latency8", 64'(lat), 64'd9);
    chk("product8", {48'b0, p8}, {48'b0, sb8.pop_front()});
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("post_hs_valid8", {63'b0, ov8}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    iv32 = 0; a32 = 0; b32 = 0; sm32 = 0; or32 = 0;
    iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; or8 = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", {63'b0, ir32}, 64'd1);
    chk("rst_busy", {63'b0, bz32}, 64'd0);
    chk("rst_valid", {63'b0, ov32}, 64'd0);
    chk("rst_prod", p32, 64'd0);

    op32(-32'sd7, 32'd3, 1'b1, 0);
    chk("abs_m7x3", p32, 64'hFFFF_FFFF_FFFF_FFEB);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);
    chk("abs_ffu", p32, 64'hFFFF_FFFE_0000_0001);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    chk("abs_ffs", p32, 64'h0000_0000_0000_0001);
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 2);
    chk("abs_minmin", p32, 64'h4000_0000_0000_0000);
    op32(32'd0, 32'd0, 1'b1, 0);
    op32(32'd0, 32'h1234_5678, 1'b0, 0);
    op32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1);
    for (int i = 0; i < 16; i++) op32($urandom, $urandom, i[0], i % 3);

    op8(8'h80, 8'hFF, 1'b1);
    chk("abs8_s", {48'b0, p8}, 64'h0080);
    op8(8'h80, 8'hFF, 1'b0);
    chk("abs8_u", {48'b0, p8}, 64'h7F80);
    for (int i = 0; i < 12; i++) op8($urandom, $urandom, i[0]);

    // Reset on the 10th CALC cycle discards the operation.
    iv32 = 1'b1; a32 = 32'd9; b32 = 32'd9; sm32 = 1'b0;
    tick();
    iv32 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_busy", {63'b0, bz32}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", {63'b0, ov32}, 64'd0);
    chk("mid_rst_prod", p32, 64'd0);
    chk("mid_rst_ready", {63'b0, ir32}, 64'd1);
    chk("mid_rst_busy", {63'b0, bz32}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ov32) chk("mid_rst_stray_valid", {63'b0, ov32}, 64'd0);
    end
    op32(32'd5, -32'sd2, 1'b1, 0);
    chk("abs_5xm2", p32, 64'hFFFF_FFFF_FFFF_FFF6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
